// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and helpers for the iterative divide unit.
//               Defines the divide opcode encoding (funct3[1:0]), the
//               divider FSM state encoding, and opcode classification
//               helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } div_state_e;

  // DIV and REM interpret their operands as two's complement.
  function automatic logic is_signed_op(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic is_rem_op(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration. Shifts the
//               next dividend bit (MSB of Q) into the partial remainder,
//               subtracts M if it fits, and shifts the result bit into Q.
// Ports       : rem_i [WIDTH:0]   partial remainder in
//               q_i   [WIDTH-1:0] dividend/quotient shift register in
//               m_i   [WIDTH:0]   divisor magnitude
//               rem_o [WIDTH:0]   partial remainder out
//               q_o   [WIDTH-1:0] shift register out (new quotient bit LSB)
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] q_o
);

  // One extra bit on the shifted value so the compare sees the full
  // (WIDTH+1)-bit remainder before the shift.
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_shift = {rem_i, q_i[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, m_i});
  assign w_diff  = w_shift[WIDTH:0] - m_i;
  assign rem_o   = w_ge ? w_diff : w_shift[WIDTH:0];
  assign q_o     = {q_i[WIDTH-2:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/div_unit_param.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_param
// Description : Iterative RV32M-style divider (DIV/DIVU/REM/REMU) with
//               early exit for divide-by-zero, signed overflow and
//               |dividend| < |divisor|, ROB flush, and a valid/yumi result
//               handshake. UNROLL restoring steps are retired per cycle.
// Ports       : clk, reset_n (async active-low)
//               valid_in/ready          operand handshake
//               op, dividend, divisor, tag_in
//               flush                   squash in-flight op
//               valid_out/yumi_in       result handshake
//               result, tag_out         registered result and ROB tag
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit_param
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             valid_out,
  input  logic             yumi_in,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int               STEPS    = WIDTH / UNROLL;
  localparam int               CNT_W    = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q;
  div_op_e          op_q;
  logic             sign_a_q, sign_b_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   m_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic [TAG_W-1:0] tag_q;

  // Accept-side decode of the incoming operands.
  div_op_e        w_op;
  logic           w_signed, w_is_rem;
  logic           w_neg_a, w_neg_b;
  logic [WIDTH:0] w_abs_a, w_abs_b;
  logic           w_div_zero, w_ovf, w_small;

  assign w_op     = div_op_e'(op);
  assign w_signed = is_signed_op(w_op);
  assign w_is_rem = is_rem_op(w_op);
  assign w_neg_a  = w_signed & dividend[WIDTH-1];
  assign w_neg_b  = w_signed & divisor[WIDTH-1];
  // Sign-extend before negating so |MIN| = 2^(WIDTH-1) is exact.
  assign w_abs_a  = w_neg_a ? -{dividend[WIDTH-1], dividend} : {1'b0, dividend};
  assign w_abs_b  = w_neg_b ? -{divisor[WIDTH-1], divisor}   : {1'b0, divisor};
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = w_signed && (dividend == MIN_VAL) && (divisor == '1);
  assign w_small    = (w_abs_a < w_abs_b);

  // Restoring-step chain, UNROLL stages deep.
  logic [UNROLL:0][WIDTH:0]   w_rem;
  logic [UNROLL:0][WIDTH-1:0] w_quo;

  assign w_rem[0] = rem_q;
  assign w_quo[0] = quo_q;

  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_unroll
      div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (w_rem[gi]),
        .q_i   (w_quo[gi]),
        .m_i   (m_q),
        .rem_o (w_rem[gi+1]),
        .q_o   (w_quo[gi+1])
      );
    end
  endgenerate

  // Sign correction applied once the magnitudes are final.
  logic             w_fix_qneg, w_fix_rneg;
  logic [WIDTH-1:0] w_quo_fix, w_rem_fix;

  assign w_fix_qneg = is_signed_op(op_q) && (sign_a_q ^ sign_b_q);
  assign w_fix_rneg = is_signed_op(op_q) && sign_a_q;
  assign w_quo_fix  = w_fix_qneg ? -quo_q : quo_q;
  assign w_rem_fix  = w_fix_rneg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_DIV;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (flush) begin
      // Flush beats both a new op and a pending yumi.
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_in) begin
            op_q     <= w_op;
            tag_q    <= tag_in;
            sign_a_q <= dividend[WIDTH-1];
            sign_b_q <= divisor[WIDTH-1];
            if (w_div_zero) begin
              result_q <= w_is_rem ? dividend : '1;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end else if (w_ovf) begin
              result_q <= w_is_rem ? '0 : MIN_VAL;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end else if (w_small) begin
              result_q <= w_is_rem ? dividend : '0;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= w_abs_a[WIDTH-1:0];
              m_q     <= w_abs_b;
              cnt_q   <= CNT_INIT;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= w_rem[UNROLL];
          quo_q <= w_quo[UNROLL];
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          result_q <= is_rem_op(op_q) ? w_rem_fix : w_quo_fix;
          valid_q  <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (yumi_in) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign valid_out = valid_q;
  assign result    = result_q;
  assign tag_out   = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit_param
// Description : Self-checking bench for div_unit_param. Drives a default
//               (UNROLL=1) and an UNROLL=2 instance with shared stimulus and
//               compares result, tag and latency against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [1:0]  op_s;
  logic [31:0] dividend_s, divisor_s;
  logic [3:0]  tag_s;
  logic        flush;
  logic        yumi_in;

  logic        ready0, ready1;
  logic        valid_out0, valid_out1;
  logic [31:0] result0, result1;
  logic [3:0]  tag_out0, tag_out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit_param #(.WIDTH(32), .TAG_W(4), .UNROLL(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready(ready0),
    .op(op_s), .dividend(dividend_s), .divisor(divisor_s), .tag_in(tag_s),
    .flush(flush), .valid_out(valid_out0), .yumi_in(yumi_in),
    .result(result0), .tag_out(tag_out0)
  );

  div_unit_param #(.WIDTH(32), .TAG_W(4), .UNROLL(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready(ready1),
    .op(op_s), .dividend(dividend_s), .divisor(divisor_s), .tag_in(tag_s),
    .flush(flush), .valid_out(valid_out1), .yumi_in(yumi_in),
    .result(result1), .tag_out(tag_out1)
  );

  // Reference: 64-bit arithmetic gives truncating division and makes
  // MIN / -1 wrap to MIN when cut back to 32 bits.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    bit     sgn;
    sgn = (o == 2'b00) || (o == 2'b10);
    sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (b == 32'd0) begin
      q = -1;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic bit ref_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    bit     sgn;
    sgn = (o == 2'b00) || (o == 2'b10);
    sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (b == 32'd0) return 1'b1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    return sa < sb;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input int hold, input string name);
    int          lat0, lat1, cyc;
    logic [31:0] exp;
    bit          sp;
    exp = ref_res(o, a, b);
    sp  = ref_special(o, a, b);
    check({name, "/ready"}, {63'd0, ready0}, 64'd1);
    op_s = o; dividend_s = a; divisor_s = b; tag_s = t; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    cyc = 1; lat0 = -1; lat1 = -1;
    while (cyc <= 60) begin
      if (valid_out0 && lat0 < 0) lat0 = cyc;
      if (valid_out1 && lat1 < 0) lat1 = cyc;
      if (lat0 >= 0 && lat1 >= 0) break;
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "/lat_u1"}, 64'(lat0), sp ? 64'd1 : 64'd34);
    check({name, "/lat_u2"}, 64'(lat1), sp ? 64'd1 : 64'd18);
    check({name, "/res_u1"}, {32'd0, result0}, {32'd0, exp});
    check({name, "/res_u2"}, {32'd0, result1}, {32'd0, exp});
    check({name, "/tag_u1"}, {60'd0, tag_out0}, {60'd0, t});
    check({name, "/tag_u2"}, {60'd0, tag_out1}, {60'd0, t});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "/hold_v"}, {63'd0, valid_out0}, 64'd1);
      check({name, "/hold_res"}, {32'd0, result0}, {32'd0, exp});
      check({name, "/hold_tag"}, {60'd0, tag_out0}, {60'd0, t});
    end
    yumi_in = 1'b1;
    @(posedge clk); #1;
    yumi_in = 1'b0;
    check({name, "/post_v"}, {62'd0, valid_out0, valid_out1}, 64'd0);
    check({name, "/post_rdy"}, {62'd0, ready0, ready1}, 64'd3);
  endtask

  initial begin
    int          cyc;
    bit          seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset_n = 1'b0; valid_in = 1'b0; op_s = 2'b00; dividend_s = '0;
    divisor_s = '0; tag_s = '0; flush = 1'b0; yumi_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/ready", {62'd0, ready0, ready1}, 64'd3);
    check("reset/valid", {62'd0, valid_out0, valid_out1}, 64'd0);
    check("reset/result", {32'd0, result0}, 64'd0);
    check("reset/tag", {60'd0, tag_out0}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'b00, -32'sd100, 32'd3, 4'd5, 5, "div_m100_3");
    run_op(2'b00, -32'sd100, -32'sd3, 4'd6, 0, "div_m100_m3");
    run_op(2'b10, -32'sd100, 32'd3, 4'd7, 0, "rem_m100_3");
    run_op(2'b11, 32'hFFFF_FFFF, 32'd10, 4'd8, 0, "remu_max_10");
    run_op(2'b01, 32'h8000_0000, 32'd2, 4'd9, 0, "divu_min_2");
    run_op(2'b01, 32'd12345, 32'd0, 4'd10, 0, "divu_by0");
    run_op(2'b10, 32'd12345, 32'd0, 4'd11, 0, "rem_by0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 0, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd13, 0, "rem_ovf");
    run_op(2'b00, 32'd2, 32'd7, 4'd14, 0, "div_2_7");
    run_op(2'b10, -32'sd2, 32'd7, 4'd15, 0, "rem_m2_7");

    // Flush in CALC cycle 10: no result may ever appear.
    op_s = 2'b00; dividend_s = 32'h1234_5678; divisor_s = 32'd7; tag_s = 4'd3;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush/ready", {62'd0, ready0, ready1}, 64'd3);
    check("flush/valid", {62'd0, valid_out0, valid_out1}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | valid_out0 | valid_out1;
    end
    check("flush/never_valid", {63'd0, seen}, 64'd0);
    run_op(2'b01, 32'd100, 32'd3, 4'd4, 0, "divu_after_flush");

    // Flush in the same cycle as valid_in: the op must not be accepted.
    op_s = 2'b01; dividend_s = 32'd1000; divisor_s = 32'd0; valid_in = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    check("flush_vs_valid/ready", {62'd0, ready0, ready1}, 64'd3);
    check("flush_vs_valid/valid", {62'd0, valid_out0, valid_out1}, 64'd0);

    // Async reset mid-CALC.
    op_s = 2'b01; dividend_s = 32'hDEAD_BEEF; divisor_s = 32'd3; tag_s = 4'd9;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset/valid", {62'd0, valid_out0, valid_out1}, 64'd0);
    check("areset/ready", {62'd0, ready0, ready1}, 64'd3);
    check("areset/result", {32'd0, result0}, 64'd0);
    check("areset/tag", {60'd0, tag_out0}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Randomised ops against the reference model.
    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        3: rb = 32'd0;
        default: begin
          rb = $urandom;
          ra = 32'($urandom_range(0, 50));
        end
      endcase
      run_op(ro, ra, rb, 4'(n), 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
